// File: rtl/module_mmbf_cfg_loader_pkg.sv
// Shared types and helpers for the half-band filter chain configuration loader.
// Pulled in by module_mmbf_cfg_loader and mmbf_cfg_ram.
package module_mmbf_cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    FINISH,
    ERROR
  } state_t;

  localparam int DEF_NMHBF_MAX        = 5;
  localparam int DEF_FILTER_MAX_ORDER = 32;

  // Each stage needs its taps plus three control words.
  function automatic int default_cfg_len(input int max_order, input int n_stages);
    return (max_order + 3) * n_stages;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/module_mmbf_cfg_loader_ram.sv
// mmbf_cfg_ram: configuration word store, one synchronous write port and one
// asynchronous read port. Contents are deliberately never reset.
module mmbf_cfg_ram
  import module_mmbf_cfg_loader_pkg::*;
#(
  parameter int DEPTH = 175,
  parameter int WIDTH = 24,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The address space rounds up to a power of two, so out-of-range writes are dropped here.
  always_ff @(posedge CLK) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/module_mmbf_cfg_loader.sv
// Streams a stored configuration image word by word into a cascaded half-band filter chain.
// Optional watchdog: define MMBF_CFG_LOADER_TIMEOUT_EN to abort stalled transfers with Cfg_Err.
module module_mmbf_cfg_loader
  import module_mmbf_cfg_loader_pkg::*;
#(
  parameter int NMHBF_MAX        = DEF_NMHBF_MAX,
  parameter int COEFF_WIDTH      = 24,
  parameter int FILTER_MAX_ORDER = DEF_FILTER_MAX_ORDER,
  parameter int CFG_LEN          = default_cfg_len(FILTER_MAX_ORDER, NMHBF_MAX),
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int AW = addr_width(CFG_LEN)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Wr_En,
  input  logic [AW-1:0]          Wr_Addr,
  input  logic [COEFF_WIDTH-1:0] Wr_Data,
  input  logic                   Cfg_Start,
  output logic                   Busy,
  output logic                   Cfg_Done,
  output logic                   Cfg_Err,
  output logic                   isConfig,
  output logic [COEFF_WIDTH-1:0] Data_Config,
  input  logic                   isConfigACK,
  input  logic                   isConfigDone
);

  localparam logic [AW-1:0] LAST_IDX = AW'(CFG_LEN - 1);

  if (TIMEOUT_CYCLES < 1 || CFG_LEN < 2) begin : g_param_check
    $error("module_mmbf_cfg_loader: TIMEOUT_CYCLES must be >= 1 and CFG_LEN >= 2");
  end

  state_t                 state;
  logic [AW-1:0]          idx;
  logic [AW-1:0]          rd_addr;
  logic [COEFF_WIDTH-1:0] rd_data;

  // Look one word ahead so the next word can be registered on the same edge as an ACK.
  assign rd_addr = (state == SEND && idx != LAST_IDX) ? idx + 1'b1 : '0;

  mmbf_cfg_ram #(
    .DEPTH (CFG_LEN),
    .WIDTH (COEFF_WIDTH)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (Wr_En && !Busy),
    .wr_addr (Wr_Addr),
    .wr_data (Wr_Data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef MMBF_CFG_LOADER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err;
  logic          timeout_hit;

  assign timeout_hit = (cnt >= CW'(TIMEOUT_CYCLES));
  assign Cfg_Err     = err;
`else
  assign Cfg_Err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      isConfig    <= 1'b0;
      Busy        <= 1'b0;
      Cfg_Done    <= 1'b0;
      Data_Config <= '0;
`ifdef MMBF_CFG_LOADER_TIMEOUT_EN
      cnt         <= '0;
      err         <= 1'b0;
`endif
    end else begin
      Cfg_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Cfg_Start) begin
            state       <= SEND;
            idx         <= '0;
            isConfig    <= 1'b1;
            Busy        <= 1'b1;
            Data_Config <= rd_data;
`ifdef MMBF_CFG_LOADER_TIMEOUT_EN
            cnt         <= '0;
            err         <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (isConfigACK) begin
`ifdef MMBF_CFG_LOADER_TIMEOUT_EN
            cnt <= '0;
`endif
            if (idx == LAST_IDX) begin
              state <= WAIT_DONE;
            end else begin
              idx         <= idx + 1'b1;
              Data_Config <= rd_data;
            end
          end
`ifdef MMBF_CFG_LOADER_TIMEOUT_EN
          else if (timeout_hit) begin
            state    <= ERROR;
            isConfig <= 1'b0;
            Busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (isConfigDone) begin
            state    <= FINISH;
            isConfig <= 1'b0;
            Cfg_Done <= 1'b1;
          end
`ifdef MMBF_CFG_LOADER_TIMEOUT_EN
          else if (timeout_hit) begin
            state    <= ERROR;
            isConfig <= 1'b0;
            Busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        FINISH: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        ERROR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/module_mmbf_cfg_loader.md
MODULE_MMBF_CFG_LOADER -- requirements
Module: module_mmbf_cfg_loader

Interface
REQ-001 SHALL have parameter NMHBF_MAX, default 5, number of cascaded half-band stages to configure.
REQ-002 SHALL have parameter COEFF_WIDTH, default 24, configuration word width.
REQ-003 SHALL have parameter FILTER_MAX_ORDER, default 32, max taps per stage.
REQ-004 SHALL have parameter CFG_LEN, default (FILTER_MAX_ORDER+3)*NMHBF_MAX = 175, words per full configuration.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles to wait for isConfigACK or isConfigDone.
REQ-006 SHALL use one clock and a synchronous, active-high reset: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-007 Host write port: Wr_En input 1; Wr_Addr input clog2(CFG_LEN); Wr_Data input COEFF_WIDTH.
REQ-008 Cfg_Start input 1, one-cycle start request.
REQ-009 Busy output 1, high while a transfer is in progress.
REQ-010 Cfg_Done output 1, one-cycle pulse on successful completion.
REQ-011 Cfg_Err output 1, sticky timeout flag, cleared by the next accepted Cfg_Start.
REQ-012 Filter-side port: isConfig output 1; Data_Config output COEFF_WIDTH; isConfigACK input 1, per-word accept; isConfigDone input 1, chain fully configured.

Function
REQ-013 SHALL store CFG_LEN words in an internal register file written when Wr_En=1 and Busy=0; writes with Busy=1 or Wr_Addr>=CFG_LEN are ignored.
REQ-014 FSM states: IDLE, SEND, WAIT_DONE, FINISH, ERROR.
REQ-015 IDLE: Cfg_Start=1 -> SEND next cycle, word index=0, timeout counter=0, Cfg_Err cleared.
REQ-016 SEND: isConfig=1, Data_Config=RAM[index], held stable until isConfigACK sampled 1.
REQ-017 On ACK in SEND with index<CFG_LEN-1: index+1, new word driven on the next cycle, counter cleared; back-to-back ACKs transfer one word per cycle.
REQ-018 On ACK with index=CFG_LEN-1 -> WAIT_DONE; isConfig stays 1, further ACKs ignored.
REQ-019 WAIT_DONE: isConfigDone=1 -> FINISH; isConfig drops to 0 in FINISH.
REQ-020 FINISH: Cfg_Done=1 for exactly one cycle, then IDLE.
REQ-021 Cfg_Start outside IDLE is ignored; Cfg_Start in the same cycle as FINISH is ignored.
REQ-022 Busy=1 in SEND, WAIT_DONE and FINISH; 0 in IDLE and ERROR.
REQ-023 isConfigDone seen in SEND before the last ACK SHALL be ignored.
REQ-024 Latency: Cfg_Start at cycle t -> isConfig=1 and Data_Config=RAM[0] at cycle t+1.

Reset
REQ-025 On RST=1 at a clock edge: state=IDLE; isConfig, Busy, Cfg_Done, Cfg_Err=0; Data_Config=0; index and counter=0.
REQ-026 RST mid-transfer SHALL abort immediately with no Cfg_Done; register file contents are not reset.

Configuration
REQ-027 Macro MMBF_CFG_LOADER_TIMEOUT_EN defined: counter runs in SEND/WAIT_DONE; reaching TIMEOUT_CYCLES -> ERROR, isConfig=0, Cfg_Err=1; ERROR -> IDLE the next cycle.
REQ-028 Macro undefined: no counter logic, ERROR unreachable, Cfg_Err tied 0, waits indefinitely.

Structure
REQ-029 Shared package: FSM state encoding, default CFG_LEN expression, address-width function.
REQ-030 One sub-module, mmbf_cfg_ram: single-write, asynchronous-read CFG_LEN x COEFF_WIDTH register file.

Verification
REQ-031 Load RAM[i]=i+0x100, Start, ACK every cycle, Done 2 cycles after last ACK -> 175 words 0x100..0x1AE in order, one Cfg_Done pulse, isConfig low after.
REQ-032 ACK every 3rd cycle -> Data_Config stable between ACKs, no word skipped or repeated.
REQ-033 Start again while Busy, and Wr_En to addr 5 while Busy -> no restart; RAM[5] unchanged.
REQ-034 RST at word 50 -> all outputs 0 next cycle, no Cfg_Done; new Start resends from word 0.
REQ-035 With TIMEOUT_EN, TIMEOUT_CYCLES=16, never ACK -> Cfg_Err=1 and isConfig=0 at cycle 17 after the SEND entry; next Start clears Cfg_Err.
REQ-036 isConfigDone held 1 throughout -> ignored until the last ACK, then FINISH.
